// File: rtl/bus_seq_engine.sv
// rtl/bus_seq_engine.sv - program-execution core for the bus sequencer
module bus_seq_engine #(
    parameter int DATA_W     = 8,
    parameter int CFG_W      = 4,
    parameter int ADDR_W     = 8,
    parameter int WR_BIT     = 2,
    parameter int WAIT_PRESC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         start_addr,
    input  logic                      abort,
    input  logic                      resume,
    output logic                      prog_rd_en,
    output logic [ADDR_W-1:0]         prog_addr,
    input  logic [CFG_W+DATA_W:0]     prog_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic [CFG_W-1:0]          tx_cfg,
    input  logic                      rx_valid,
    input  logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      paused,
    output logic                      done,
    output logic                      error,
    output logic [ADDR_W-1:0]         pc
);

    localparam int W       = 1 + CFG_W + DATA_W;
    localparam int PRESC_W = $clog2(WAIT_PRESC + 1);
    localparam int CNT_W   = DATA_W + PRESC_W;

    localparam logic [2:0] OP_WAIT       = 3'd0;
    localparam logic [2:0] OP_COMPARE    = 3'd1;
    localparam logic [2:0] OP_COMP_JMP   = 3'd2;
    localparam logic [2:0] OP_STOP       = 3'd3;
    localparam logic [2:0] OP_PAUSE      = 3'd4;
    localparam logic [2:0] OP_UNCOND_JMP = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_XFER,
        S_RXWAIT,
        S_WAIT,
        S_PAUSED
    } state_t;

    state_t              state;
    logic                match;
    logic [DATA_W-1:0]   rx_hist0;
    logic [DATA_W-1:0]   rx_hist1;
    logic [CNT_W-1:0]    wait_cnt;

    // Fields of the word currently returned by the program RAM
    logic                word_is_xfer;
    logic [CFG_W-1:0]    word_cfg;
    logic [DATA_W-1:0]   word_data;
    logic [2:0]          word_op;
    logic                word_flag;

    assign word_is_xfer = prog_data[0];
    assign word_cfg     = prog_data[CFG_W:1];
    assign word_data    = prog_data[W-1:CFG_W+1];
    assign word_op      = prog_data[3:1];
    assign word_flag    = prog_data[4];

    // Jump offset is the data field resized to the address width
    logic [ADDR_W-1:0]   jmp_off;
    generate
        if (DATA_W >= ADDR_W) begin : g_off_trunc
            assign jmp_off = word_data[ADDR_W-1:0];
        end else begin : g_off_ext
            assign jmp_off = {{(ADDR_W-DATA_W){1'b0}}, word_data};
        end
    endgenerate

    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   jmp_target;
    logic [CNT_W-1:0]    wait_total;
    logic                cmp_hit;

    assign pc_inc     = pc + ADDR_W'(1);
    assign jmp_target = word_flag ? (pc - jmp_off) : (pc + jmp_off);
    assign wait_total = CNT_W'(word_data) * CNT_W'(WAIT_PRESC);
    assign cmp_hit    = ((word_flag ? rx_hist0 : rx_hist1) == word_data);

    logic                fetch_req;
    logic [ADDR_W-1:0]   fetch_pc;

    // Decide whether the next cycle is a FETCH and from which address
    always_comb begin
        fetch_req = 1'b0;
        fetch_pc  = pc_inc;
        case (state)
            S_IDLE: begin
                fetch_req = start;
                fetch_pc  = start_addr;
            end
            S_DECODE: begin
                if (!word_is_xfer) begin
                    case (word_op)
                        OP_WAIT:       fetch_req = (wait_total < CNT_W'(2));
                        OP_COMPARE:    fetch_req = 1'b1;
                        OP_COMP_JMP: begin
                            fetch_req = 1'b1;
                            fetch_pc  = match ? jmp_target : pc_inc;
                        end
                        OP_UNCOND_JMP: begin
                            fetch_req = 1'b1;
                            fetch_pc  = jmp_target;
                        end
                        default:       fetch_req = 1'b0;
                    endcase
                end
            end
            S_XFER:   fetch_req = tx_ready && tx_cfg[WR_BIT];
            S_RXWAIT: fetch_req = rx_valid;
            S_WAIT:   fetch_req = (wait_cnt == '0);
            S_PAUSED: begin
                fetch_req = resume;
                fetch_pc  = pc;
            end
            default:  fetch_req = 1'b0;
        endcase
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prog_rd_en <= 1'b0;
            prog_addr  <= '0;
            pc         <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_cfg     <= '0;
            busy       <= 1'b0;
            paused     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            match      <= 1'b0;
            rx_hist0   <= '0;
            rx_hist1   <= '0;
            wait_cnt   <= '0;
        end else begin
            done       <= 1'b0;
            prog_rd_en <= 1'b0;
            if (abort) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                paused   <= 1'b0;
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            error <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                    S_FETCH: state <= S_DECODE;
                    S_DECODE: begin
                        if (word_is_xfer) begin
                            tx_valid <= 1'b1;
                            tx_data  <= word_data;
                            tx_cfg   <= word_cfg;
                            state    <= S_XFER;
                        end else begin
                            case (word_op)
                                OP_WAIT: begin
                                    wait_cnt <= wait_total - CNT_W'(2);
                                    state    <= S_WAIT;
                                end
                                OP_COMPARE:    match <= cmp_hit;
                                OP_COMP_JMP:   ;
                                OP_UNCOND_JMP: ;
                                OP_STOP: begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_IDLE;
                                end
                                OP_PAUSE: begin
                                    pc     <= pc_inc;
                                    paused <= 1'b1;
                                    state  <= S_PAUSED;
                                end
                                default: begin
                                    error <= 1'b1;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_IDLE;
                                end
                            endcase
                        end
                    end
                    S_XFER: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            if (!tx_cfg[WR_BIT]) begin
                                state <= S_RXWAIT;
                            end
                        end
                    end
                    S_RXWAIT: begin
                        if (rx_valid) begin
                            rx_hist1 <= rx_hist0;
                            rx_hist0 <= rx_data;
                        end
                    end
                    S_WAIT: begin
                        if (wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - CNT_W'(1);
                        end
                    end
                    S_PAUSED: begin
                        if (resume) begin
                            paused <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase

                // Any path that continues execution lands in FETCH here
                if (fetch_req) begin
                    state      <= S_FETCH;
                    pc         <= fetch_pc;
                    prog_addr  <= fetch_pc;
                    prog_rd_en <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_seq_engine.sv
// tb/tb_bus_seq_engine.sv - scoreboard bench for bus_seq_engine
module tb_bus_seq_engine;

    localparam int DATA_W     = 8;
    localparam int CFG_W      = 4;
    localparam int ADDR_W     = 8;
    localparam int WR_BIT     = 2;
    localparam int WAIT_PRESC = 4;
    localparam int W          = 1 + CFG_W + DATA_W;

    localparam logic [2:0] OP_WAIT       = 3'd0;
    localparam logic [2:0] OP_COMPARE    = 3'd1;
    localparam logic [2:0] OP_COMP_JMP   = 3'd2;
    localparam logic [2:0] OP_STOP       = 3'd3;
    localparam logic [2:0] OP_PAUSE      = 3'd4;
    localparam logic [2:0] OP_UNCOND_JMP = 3'd5;
    localparam logic [3:0] CFG_WR        = 4'b0101;
    localparam logic [3:0] CFG_RD        = 4'b0011;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              abort;
    logic              resume;
    logic              prog_rd_en;
    logic [ADDR_W-1:0] prog_addr;
    logic [W-1:0]      prog_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic [CFG_W-1:0]  tx_cfg;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              paused;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] pc;

    bus_seq_engine #(
        .DATA_W(DATA_W), .CFG_W(CFG_W), .ADDR_W(ADDR_W),
        .WR_BIT(WR_BIT), .WAIT_PRESC(WAIT_PRESC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .abort(abort), .resume(resume), .prog_rd_en(prog_rd_en),
        .prog_addr(prog_addr), .prog_data(prog_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_cfg(tx_cfg),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .paused(paused), .done(done), .error(error), .pc(pc)
    );

    always #5 clk = ~clk;

    logic [W-1:0]      mem [256];
    logic [ADDR_W-1:0] exp_fetch [$];
    logic [11:0]       exp_tx [$];
    logic [7:0]        rx_bytes [$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                tx_hi = 0;
    int                fetch_cyc [256];
    logic [ADDR_W-1:0] exp_addr;
    logic [11:0]       exp_word;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (prog_rd_en) prog_data <= mem[prog_addr];

    function automatic logic [W-1:0] xw(input logic [7:0] d, input logic [3:0] c);
        return {d, c, 1'b1};
    endfunction

    function automatic logic [W-1:0] iw(input logic [2:0] op, input logic f, input logic [7:0] d);
        return {d, f, op, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [ADDR_W-1:0] a);
        start = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < max_cyc);
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, max_cyc);
        end else begin
            check({name, "_busy_at_done"}, 32'(busy), 32'd0);
            tick();
            check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    // Fetch-address scoreboard
    always @(negedge clk) begin
        if (prog_rd_en) begin
            fetch_cyc[prog_addr] = cyc;
            if (exp_fetch.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL fetch_unexpected: addr %0h with none expected", prog_addr);
            end else begin
                exp_addr = exp_fetch.pop_front();
                check("fetch_addr", 32'(prog_addr), 32'(exp_addr));
            end
        end
    end

    // Transfer scoreboard
    always @(negedge clk) begin
        if (tx_valid) begin
            tx_hi++;
            if (tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: data %0h cfg %0h", tx_data, tx_cfg);
                end else begin
                    exp_word = exp_tx.pop_front();
                    check("tx_word", 32'({tx_data, tx_cfg}), 32'(exp_word));
                end
            end
        end
    end

    // Read-byte responder: answers each read transfer two cycles later
    initial begin
        rx_valid = 1'b0;
        rx_data  = '0;
        forever begin
            @(negedge clk);
            if (tx_valid && tx_ready && !tx_cfg[WR_BIT]) begin
                repeat (2) @(posedge clk);
                #1;
                if (rx_bytes.size() > 0) rx_data = rx_bytes.pop_front();
                else rx_data = 8'hEE;
                rx_valid = 1'b1;
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        logic ok;
        rst = 1'b1; start = 1'b0; start_addr = '0; abort = 1'b0;
        resume = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = iw(OP_STOP, 1'b0, 8'h00);
            fetch_cyc[i] = 0;
        end
        mem[8'h02] = xw(8'hA5, CFG_WR);
        mem[8'h03] = iw(OP_STOP, 1'b0, 8'h00);
        mem[8'h10] = xw(8'h50, CFG_RD);
        mem[8'h11] = iw(OP_COMPARE, 1'b1, 8'h3C);
        mem[8'h12] = iw(OP_COMP_JMP, 1'b1, 8'h02);
        mem[8'h13] = iw(OP_STOP, 1'b0, 8'h00);
        mem[8'h20] = iw(OP_COMPARE, 1'b0, 8'h3C);
        mem[8'h21] = iw(OP_COMP_JMP, 1'b0, 8'h03);
        mem[8'h22] = iw(OP_STOP, 1'b0, 8'h00);
        mem[8'h23] = iw(3'd7, 1'b0, 8'h00);
        mem[8'h24] = iw(OP_UNCOND_JMP, 1'b1, 8'h02);
        mem[8'h30] = iw(OP_WAIT, 1'b0, 8'h03);
        mem[8'h31] = iw(OP_WAIT, 1'b0, 8'h00);
        mem[8'h32] = iw(OP_STOP, 1'b0, 8'h00);
        mem[8'h40] = xw(8'h77, CFG_WR);
        mem[8'h41] = iw(OP_STOP, 1'b0, 8'h00);
        mem[8'h50] = iw(3'd6, 1'b0, 8'h00);
        mem[8'hFF] = iw(OP_PAUSE, 1'b0, 8'h00);
        mem[8'h00] = iw(OP_STOP, 1'b0, 8'h00);

        repeat (3) tick();
        rst = 1'b0;
        check("reset_outputs",
              32'({prog_rd_en, prog_addr, tx_valid, tx_data, tx_cfg, busy, paused, done, error}), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);

        // Write then STOP
        tx_hi = 0;
        exp_fetch.push_back(8'h02); exp_fetch.push_back(8'h03);
        exp_tx.push_back({8'hA5, CFG_WR});
        start_run(8'h02);
        check("t1_first_fetch", 32'({prog_rd_en, busy, prog_addr}), 32'({1'b1, 1'b1, 8'h02}));
        wait_done("t1", 40, n);
        check("t1_cycles_to_idle", 32'(n + 1), 32'd6);
        check("t1_tx_valid_cycles", 32'(tx_hi), 32'd1);

        // Read, compare with up-jump, second read mismatches
        rx_bytes.push_back(8'h3C); rx_bytes.push_back(8'h3D);
        foreach (exp_tx[i]) ;
        exp_tx.push_back({8'h50, CFG_RD}); exp_tx.push_back({8'h50, CFG_RD});
        exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11); exp_fetch.push_back(8'h12);
        exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11); exp_fetch.push_back(8'h12);
        exp_fetch.push_back(8'h13);
        start_run(8'h10);
        wait_done("t2", 80, n);

        // Older history byte, down-jump, unconditional up-jump
        exp_fetch.push_back(8'h20); exp_fetch.push_back(8'h21);
        exp_fetch.push_back(8'h24); exp_fetch.push_back(8'h22);
        start_run(8'h20);
        wait_done("t2b", 40, n);
        check("t2b_no_error", 32'(error), 32'd0);

        // WAIT 3 with prescaler 4, then WAIT 0
        exp_fetch.push_back(8'h30); exp_fetch.push_back(8'h31); exp_fetch.push_back(8'h32);
        start_run(8'h30);
        wait_done("t3", 60, n);
        check("t3_cycles_to_idle", 32'(n + 1), 32'd18);
        check("t3_wait3_gap", 32'(fetch_cyc[8'h31] - fetch_cyc[8'h30]), 32'd13);
        check("t3_wait0_gap", 32'(fetch_cyc[8'h32] - fetch_cyc[8'h31]), 32'd2);

        // Stalled write aborted, then rerun
        tx_ready = 1'b0;
        exp_fetch.push_back(8'h40);
        start_run(8'h40);
        tick();
        tick();
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(tx_valid && tx_data == 8'h77 && tx_cfg == CFG_WR)) ok = 1'b0;
            tick();
        end
        check("t4_tx_held_stable", 32'(ok), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_after_abort", 32'({tx_valid, busy, done}), 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done || busy || tx_valid) ok = 1'b0;
            tick();
        end
        check("t4_quiet_after_abort", 32'(ok), 32'd1);
        tx_ready = 1'b1;
        exp_fetch.push_back(8'h40); exp_fetch.push_back(8'h41);
        exp_tx.push_back({8'h77, CFG_WR});
        start_run(8'h40);
        wait_done("t4_rerun", 40, n);
        check("t4_rerun_cycles", 32'(n + 1), 32'd6);

        // PAUSE at the top address wraps to 0
        exp_fetch.push_back(8'hFF);
        start_run(8'hFF);
        tick();
        tick();
        check("t5_paused_state", 32'({paused, busy, pc}), 32'({1'b1, 1'b1, 8'h00}));
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!paused || prog_rd_en) ok = 1'b0;
            tick();
        end
        check("t5_paused_hold", 32'(ok), 32'd1);
        exp_fetch.push_back(8'h00);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("t5_resume_fetch", 32'({paused, prog_rd_en, prog_addr}), 32'({1'b0, 1'b1, 8'h00}));
        wait_done("t5", 20, n);
        check("t5_cycles", 32'(n), 32'd2);

        // Illegal opcode sets error, next start clears it
        exp_fetch.push_back(8'h50);
        start_run(8'h50);
        wait_done("t6", 20, n);
        check("t6_cycles", 32'(n), 32'd2);
        check("t6_error_set", 32'(error), 32'd1);
        exp_fetch.push_back(8'h00);
        start_run(8'h00);
        check("t6_error_cleared", 32'(error), 32'd0);
        wait_done("t6b", 20, n);

        repeat (3) tick();
        check("end_fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
        check("end_tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("end_rx_queue_empty", 32'(rx_bytes.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
